// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch / memory-wait pipeline control,
// EX-stage forwarding selects, a memory wait timeout flag and saturating
// stall/flush performance counters.
module hazard_stall_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_load_rt,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_write_addr,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_addr,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic              timeout_nxt;
    logic              freeze;
    logic              load_use;
    logic              flush_req;
    logic              stall_req;

    // EX/MEM result beats MEM/WB result; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_addr,
        input logic       wb_we,
        input logic [4:0] wb_addr,
        input logic [4:0] src
    );
        if (mem_we && (mem_addr != 5'd0) && (mem_addr == src)) begin
            return 2'b10;
        end else if (wb_we && (wb_addr != 5'd0) && (wb_addr == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Hazard detection; freeze outranks load-use, which outranks a taken branch.
    always_comb begin
        freeze    = dmem_req && !dmem_ready;
        load_use  = ex_mem_read && (ex_load_rt != 5'd0) &&
                    ((ex_load_rt == id_rs) || (ex_load_rt == id_rt));
        flush_req = branch_taken && !freeze && !load_use;
        stall_req = freeze || load_use;
    end

    // Pipeline register controls and forwarding selects; reset holds the front end and flushes it.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pipe_freeze = freeze;
            if (freeze) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
            end
            fwd_a = fwd_sel(mem_reg_write, mem_write_addr, wb_reg_write, wb_write_addr, ex_rs);
            fwd_b = fwd_sel(mem_reg_write, mem_write_addr, wb_reg_write, wb_write_addr, ex_rt);
        end
    end

    // Wait FSM; the timeout flag sets on the same edge wcnt reaches MAX_WAIT,
    // i.e. at the end of the MAX_WAIT-th consecutive not-ready cycle.
    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        timeout_nxt = mem_timeout;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else begin
                    if (wcnt >= WAIT_LAST) begin
                        timeout_nxt = 1'b1;
                    end
                    if (wcnt != WAIT_MAX) begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
            end
        endcase
    end

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Saturating performance counters: stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_req && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_req && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
